// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the L1 data cache and its controller.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cline;
  typedef logic [3:0]   lc3b_c_offset;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} lc3b_dcache_state_t;

endpackage

// File: rtl/dcache_control.sv
// Miss-handling FSM for the L1 data cache: writeback of a dirty victim, then line fill.
module dcache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic valid,
  input  logic dirty,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic mem_resp,
  output logic load_line,
  output logic write_word,
  output logic addr_sel
);

  lc3b_dcache_state_t state_q;
  logic               pmem_read_q;
  logic               pmem_write_q;
  logic               req;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (valid && dirty) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
            end else begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state_q      <= FILL;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state_q     <= IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign mem_resp   = (state_q == IDLE) && req && hit;
  // Write hits (including read+write together) update the array at the edge.
  assign write_word = mem_resp && mem_write;
  assign load_line  = (state_q == FILL) && pmem_resp;
  assign addr_sel   = pmem_write_q;

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: arrays and datapath.
module l1_dcache
  import lc3b_types::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output lc3b_cline   pmem_wdata,
  input  lc3b_cline   pmem_rdata,
  input  logic        pmem_resp
);

  localparam int unsigned IW = $clog2(NUM_SETS);
  localparam int unsigned TW = 12 - IW;

  logic            valid_q [NUM_SETS];
  logic            dirty_q [NUM_SETS];
  logic [TW-1:0]   tag_q   [NUM_SETS];
  lc3b_cline       data_q  [NUM_SETS];

  logic [TW-1:0]   tag;
  logic [IW-1:0]   idx;
  logic [2:0]      word;
  logic            hit;
  logic            load_line;
  logic            write_word;
  logic            addr_sel;
  lc3b_cline       line;
  lc3b_cline       wline;
  logic            unused_addr_bit;

  assign tag             = mem_address[15:4+IW];
  assign idx             = mem_address[3+IW:4];
  assign word            = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign line            = data_q[idx];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag);

  dcache_control u_control (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .hit        (hit),
    .valid      (valid_q[idx]),
    .dirty      (dirty_q[idx]),
    .pmem_resp  (pmem_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .mem_resp   (mem_resp),
    .load_line  (load_line),
    .write_word (write_word),
    .addr_sel   (addr_sel)
  );

  always_comb begin
    wline = line;
    if (mem_byte_enable[0]) wline[{word, 4'b0000} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) wline[{word, 4'b1000} +: 8] = mem_wdata[15:8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else if (load_line) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_word) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (write_word) begin
      data_q[idx] <= wline;
    end
  end

  assign mem_rdata    = mem_resp ? line[{word, 4'b0000} +: 16] : 16'h0000;
  assign pmem_address = addr_sel  ? {tag_q[idx], idx, lc3b_c_offset'(0)} :
                        pmem_read ? {mem_address[15:4], lc3b_c_offset'(0)} : 16'h0000;
  assign pmem_wdata   = pmem_write ? line : '0;

endmodule
